// File: rtl/tick_event_scheduler.sv
// rtl/tick_event_scheduler.sv - shared base prescaler feeding periodic channels, serialised onto one event port
// Optional feature: define EVT_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, channel 0 highest)
module tick_event_scheduler #(
  parameter int BASE_COUNT = 1_485_000,
  parameter int NUM_CH     = 4,
  parameter int PER_W      = 8
) (
  input  logic                      clk_148Mhz,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [PER_W-1:0]          cfg_period,
  output logic                      base_tick,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [$clog2(NUM_CH)-1:0] ev_id,
  output logic [NUM_CH-1:0]         overrun
);

  localparam int ID_W = $clog2(NUM_CH);
  localparam int PC_W = $clog2(BASE_COUNT);
  localparam logic [PC_W-1:0] PCNT_MAX = PC_W'(BASE_COUNT - 1);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_APPLY = 1'b1;

  logic [PC_W-1:0]  pcnt;
  logic [0:0]       state;
  logic [ID_W-1:0]  cfg_ch_q;
  logic [PER_W-1:0] cfg_period_q;
  logic [PER_W-1:0] period [NUM_CH];
  logic [PER_W-1:0] ccnt   [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] cfg_hit;
  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] grant;
  logic              ch_tick;
  logic              load;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   rr_start;

  assign cfg_ready = (state == ST_IDLE);
  assign ch_tick   = base_tick & enable;
  assign load      = ~ev_valid | ev_ready;
  // A channel being rewritten this cycle may not be granted: its pending bit is being discarded.
  assign req       = pending & ~cfg_hit;

  // Per-channel decode: config target this cycle, and which channels wrap on this base tick
  always_comb begin
    cfg_hit = '0;
    fire    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = (state == ST_APPLY) && (cfg_ch_q == ID_W'(i));
      fire[i]    = ch_tick && (period[i] != '0) && !cfg_hit[i] &&
                   (ccnt[i] == period[i] - PER_W'(1));
    end
  end

  // Arbiter: first requesting channel searching upward (with wrap) from rr_start
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_start) + k) % NUM_CH;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // Grant vector: the winner is consumed only when the output register is loading
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = load && win_found && (win_id == ID_W'(i));
    end
  end

`ifdef EVT_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;
  assign rr_start = rr_ptr;

  // Round-robin pointer: next search starts just past the last granted channel
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (load && win_found) begin
      rr_ptr <= (win_id == ID_W'(NUM_CH - 1)) ? '0 : win_id + ID_W'(1);
    end
  end
`else
  assign rr_start = '0;
`endif

  // Base prescaler: base_tick is a registered pulse following the last count of each wrap
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else if (enable) begin
      base_tick <= (pcnt == PCNT_MAX);
      pcnt      <= (pcnt == PCNT_MAX) ? '0 : pcnt + PC_W'(1);
    end else begin
      base_tick <= 1'b0;
    end
  end

  // Config FSM: accept a request in IDLE, apply it in the following cycle
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cfg_ch_q     <= '0;
      cfg_period_q <= '0;
    end else if (state == ST_IDLE) begin
      if (cfg_valid) begin
        cfg_ch_q     <= cfg_ch;
        cfg_period_q <= cfg_period;
        state        <= ST_APPLY;
      end
    end else begin
      state <= ST_IDLE;
    end
  end

  // Channel counters: a config write wins over a base tick on the same channel
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        ccnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit[i]) begin
          period[i] <= cfg_period_q;
          ccnt[i]   <= '0;
        end else if (ch_tick && (period[i] != '0)) begin
          ccnt[i] <= fire[i] ? '0 : ccnt[i] + PER_W'(1);
        end
      end
    end
  end

  // Pending bits and sticky overrun: a fire landing on an ungranted pending bit is lost
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= ((pending & ~grant) | fire) & ~cfg_hit;
      overrun <= overrun | (fire & pending & ~grant);
    end
  end

  // One-entry event register: reload from the arbiter whenever empty or being consumed
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
    end else if (load) begin
      if (win_found) begin
        ev_valid <= 1'b1;
        ev_id    <= win_id;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// tb/tb_tick_event_scheduler.sv - self-checking bench for tick_event_scheduler against a behavioural model
module tb_tick_event_scheduler;

  localparam int BC = 4;
  localparam int NC = 4;
  localparam int PW = 8;
  localparam int IW = 2;

  logic          clk_148Mhz = 1'b0;
  logic          reset      = 1'b1;
  logic          enable     = 1'b0;
  logic          cfg_valid  = 1'b0;
  logic          ev_ready   = 1'b1;
  logic [IW-1:0] cfg_ch     = '0;
  logic [PW-1:0] cfg_period = '0;
  logic          cfg_ready;
  logic          base_tick;
  logic          ev_valid;
  logic [IW-1:0] ev_id;
  logic [NC-1:0] overrun;

  tick_event_scheduler #(.BASE_COUNT(BC), .NUM_CH(NC), .PER_W(PW)) dut (
    .clk_148Mhz (clk_148Mhz),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .base_tick  (base_tick),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_id      (ev_id),
    .overrun    (overrun)
  );

  always #5 clk_148Mhz = ~clk_148Mhz;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: enabled-cycle count, ticks seen per channel since its last config
  bit m_live = 1'b0;
  int m_en_cycles;
  bit m_tick;
  int m_period [NC];
  int m_ticks  [NC];
  bit m_pend   [NC];
  bit m_ovr    [NC];
  bit m_valid;
  int m_id;
  int m_rr;
  bit m_busy;
  int m_cch;
  int m_cper;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ovr_vec();
    int v = 0;
    for (int i = 0; i < NC; i++) if (m_ovr[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    m_en_cycles = 0;
    m_tick      = 1'b0;
    m_valid     = 1'b0;
    m_id        = 0;
    m_rr        = 0;
    m_busy      = 1'b0;
    m_cch       = 0;
    m_cper      = 0;
    for (int i = 0; i < NC; i++) begin
      m_period[i] = 0;
      m_ticks[i]  = 0;
      m_pend[i]   = 1'b0;
      m_ovr[i]    = 1'b0;
    end
  endtask

  task automatic model_step();
    bit adv;
    bit fires   [NC];
    bit blocked [NC];
    int win;
    int start;
    int c;
    adv = m_tick && enable;
    for (int i = 0; i < NC; i++) begin
      blocked[i] = m_busy && (m_cch == i);
      fires[i]   = 1'b0;
      if (adv && m_period[i] != 0 && !blocked[i]) begin
        m_ticks[i]++;
        fires[i] = (m_ticks[i] % m_period[i]) == 0;
      end
    end
`ifdef EVT_ROUND_ROBIN_EN
    start = m_rr;
`else
    start = 0;
`endif
    win = -1;
    if (!m_valid || ev_ready) begin
      for (int k = 0; k < NC; k++) begin
        c = (start + k) % NC;
        if (win < 0 && m_pend[c] && !blocked[c]) win = c;
      end
      if (win >= 0) begin
        m_valid = 1'b1;
        m_id    = win;
        m_rr    = (win + 1) % NC;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (fires[i] && m_pend[i] && win != i) m_ovr[i] = 1'b1;
      m_pend[i] = (m_pend[i] && win != i) || fires[i];
    end
    if (m_busy) begin
      m_period[m_cch] = m_cper;
      m_ticks[m_cch]  = 0;
      m_pend[m_cch]   = 1'b0;
      m_busy          = 1'b0;
    end else if (cfg_valid) begin
      m_busy = 1'b1;
      m_cch  = int'(cfg_ch);
      m_cper = int'(cfg_period);
    end
    if (enable) begin
      m_tick = (m_en_cycles % BC) == (BC - 1);
      m_en_cycles++;
    end else begin
      m_tick = 1'b0;
    end
  endtask

  // Compare process: every cycle the DUT is out of reset, outputs must match the model
  always @(negedge clk_148Mhz) begin
    if (m_live && !reset) begin
      check("base_tick", int'(base_tick), int'(m_tick));
      check("cfg_ready", int'(cfg_ready), int'(!m_busy));
      check("ev_valid", int'(ev_valid), int'(m_valid));
      if (m_valid) check("ev_id", int'(ev_id), m_id);
      check("overrun", int'(overrun), ovr_vec());
    end
  end

  task automatic step();
    @(posedge clk_148Mhz);
    #1;
    if (m_live) model_step();
  endtask

  task automatic do_reset();
    m_live    = 1'b0;
    reset     = 1'b1;
    cfg_valid = 1'b0;
    enable    = 1'b0;
    ev_ready  = 1'b1;
    #1;
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_ev_valid", int'(ev_valid), 0);
    check("rst_base_tick", int'(base_tick), 0);
    check("rst_overrun", int'(overrun), 0);
    repeat (2) @(posedge clk_148Mhz);
    #1;
    reset = 1'b0;
    model_reset();
    m_live = 1'b1;
    enable = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int per);
    cfg_valid  = 1'b1;
    cfg_ch     = IW'(ch);
    cfg_period = PW'(per);
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic wait_ev(input string name, input int budget);
    int n = 0;
    while (!ev_valid && n < budget) begin
      step();
      n++;
    end
    check(name, int'(ev_valid), 1);
  endtask

  task automatic wait_tick(input string name, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!base_tick && n < budget);
    check(name, int'(base_tick), 1);
  endtask

  task automatic expect_ev(input string name, input int id);
    check(name, ev_valid ? int'(ev_id) : -1, id);
  endtask

  initial begin
    int ticks;
    int evs;
    int cyc;
    int tq[$];
    int eq[$];

    // 1: no config -> base_tick every 4 clk, no events
    do_reset();
    ticks = 0;
    evs   = 0;
    repeat (40) begin
      step();
      ticks += int'(base_tick);
      evs   += int'(ev_valid);
    end
    check("t1_ticks", ticks, 10);
    check("t1_events", evs, 0);
    check("t1_cfg_ready", int'(cfg_ready), 1);

    // 2: ch1 period 3 -> events every 12 clk, first 2 clk after 3rd tick
    do_reset();
    cfg_write(1, 3);
    cyc = 0;
    repeat (60) begin
      step();
      cyc++;
      if (base_tick) tq.push_back(cyc);
      if (ev_valid && ev_id == 2'd1) eq.push_back(cyc);
    end
    if (tq.size() >= 3 && eq.size() >= 2) begin
      check("t2_first_latency", eq[0] - tq[2], 2);
      check("t2_interval", eq[1] - eq[0], 12);
    end else begin
      check("t2_event_count", eq.size(), 5);
    end

    // 3: ch0/2/3 period 1 -> ids 0,2,3 on consecutive cycles, three rounds
    do_reset();
    cfg_write(0, 1);
    cfg_write(2, 1);
    cfg_write(3, 1);
    repeat (8) step();
    for (int r = 0; r < 3; r++) begin
      wait_tick("t3_tick_timeout", 10);
      step();
      step();
      expect_ev("t3_id_a", 0);
      step();
      expect_ev("t3_id_b", 2);
      step();
      expect_ev("t3_id_c", 3);
    end

    // 4: stall the port with ch0 firing -> id held, overrun[0] set
    do_reset();
    cfg_write(0, 1);
    wait_ev("t4_ev_timeout", 20);
    ev_ready = 1'b0;
    repeat (12) step();
    check("t4_valid_held", int'(ev_valid), 1);
    check("t4_id_held", int'(ev_id), 0);
    check("t4_overrun0", int'(overrun[0]), 1);
    ev_ready = 1'b1;
    repeat (12) step();

    // 5: freeze for 20 clk -> no ticks, no events; resume from frozen counts
    do_reset();
    cfg_write(1, 3);
    repeat (7) step();
    enable = 1'b0;
    repeat (3) step();
    ticks = 0;
    evs   = 0;
    repeat (17) begin
      step();
      ticks += int'(base_tick);
      evs   += int'(ev_valid);
    end
    check("t5_frozen_ticks", ticks, 0);
    check("t5_frozen_events", evs, 0);
    enable = 1'b1;
    repeat (40) step();

    // 6: reconfigure ch1 to 0 while pending -> no ch1 event; async reset mid-handshake
    do_reset();
    cfg_write(0, 1);
    cfg_write(1, 1);
    ev_ready = 1'b0;
    wait_ev("t6_ev_timeout", 20);
    step();
    cfg_write(1, 0);
    ev_ready = 1'b1;
    evs = 0;
    repeat (12) begin
      step();
      if (ev_valid && ev_id == 2'd1) evs++;
    end
    check("t6_ch1_events", evs, 0);
    ev_ready = 1'b0;
    wait_ev("t6_ev2_timeout", 20);
    #2;
    m_live = 1'b0;
    reset  = 1'b1;
    #1;
    check("t6_async_ev_valid", int'(ev_valid), 0);
    check("t6_async_overrun", int'(overrun), 0);

    // Randomised traffic against the model, with one asynchronous reset midway
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      enable     = ($urandom_range(0, 9) != 0);
      ev_ready   = ($urandom_range(0, 3) != 0);
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_ch     = IW'($urandom_range(0, NC - 1));
      cfg_period = PW'($urandom_range(0, 4));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
